// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of {instr, pc} with immsrc/rs2_1 predecoded on entry.
// Optional same-cycle bypass of an empty queue via `define FETCHQ_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [2:0]  out_immsrc,
    output logic        out_rs2_1
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  immsrc;
        logic        rs2_1;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             in_entry;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               empty;
    logic               bypass;
    logic               push;
    logic               pop;
    logic               bypass_take;
    logic               write_en;
    logic               read_en;

    // Immediate-select predecode, evaluated once on the write side.
    function automatic logic [2:0] predecode_imm(input logic [31:0] instr);
        logic [2:0] imm;
        imm = 3'b000;
        case (instr[6:0])
            7'b0010011: imm = (instr[14:12] == 3'b011) ? 3'b011 : 3'b000;
            7'b0100011: imm = 3'b001;
            7'b0110111,
            7'b0010111: imm = 3'b010;
            7'b1100011: imm = 3'b100;
            7'b0001011: imm = 3'b101;
            default:    imm = 3'b000;
        endcase
        return imm;
    endfunction

    assign in_entry = '{
        instr:  in_instr,
        pc:     in_pc,
        immsrc: predecode_imm(in_instr),
        rs2_1:  (in_instr[24:20] == 5'd1)
    };

    assign empty    = (count == '0);
    assign in_ready = (count != CNT_W'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
    assign bypass = empty & in_valid;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid   = (!empty | bypass) & !flush;
    assign push        = in_valid & in_ready & !flush;
    assign pop         = out_valid & out_ready;
    // A bypassed instruction consumed in its arrival cycle never touches storage.
    assign bypass_take = bypass & pop;
    assign write_en    = push & !bypass_take;
    assign read_en     = pop & !bypass_take;
    assign head        = bypass ? in_entry : mem[rd_ptr];

    // Head outputs are zeroed whenever no valid entry is presented.
    always_comb begin
        out_instr  = '0;
        out_pc     = '0;
        out_immsrc = '0;
        out_rs2_1  = 1'b0;
        if (out_valid) begin
            out_instr  = head.instr;
            out_pc     = head.pc;
            out_immsrc = head.immsrc;
            out_rs2_1  = head.rs2_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (write_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (read_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(write_en) - CNT_W'(read_en);
        end
    end

    // Entry storage is deliberately unreset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (write_en) mem[wr_ptr] <= in_entry;
    end

endmodule
